// File: rtl/apb_exe_pkg.sv
// Shared definitions for the APB front-end of the exe unit.
//   - byte offsets of every register in the map, and their word indices
//     (PADDR[4:2]) as used by the decoder
//   - bit positions inside CTRL and STATUS
//   - sequencer state encoding
package apb_exe_pkg;

  typedef logic [2:0] reg_idx_t;

  localparam logic [7:0] ADDR_ARG_A  = 8'h00;
  localparam logic [7:0] ADDR_ARG_B  = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_RESULT = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h14;

  localparam reg_idx_t IDX_ARG_A  = reg_idx_t'(ADDR_ARG_A  >> 2);
  localparam reg_idx_t IDX_ARG_B  = reg_idx_t'(ADDR_ARG_B  >> 2);
  localparam reg_idx_t IDX_CTRL   = reg_idx_t'(ADDR_CTRL   >> 2);
  localparam reg_idx_t IDX_RESULT = reg_idx_t'(ADDR_RESULT >> 2);
  localparam reg_idx_t IDX_STATUS = reg_idx_t'(ADDR_STATUS >> 2);
  localparam reg_idx_t IDX_IRQ_EN = reg_idx_t'(ADDR_IRQ_EN >> 2);

  localparam int START_BIT = 8;  // CTRL
  localparam int DONE_BIT  = 8;  // STATUS
  localparam int BUSY_BIT  = 9;  // STATUS

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT
  } exe_seq_state_t;

endpackage

// File: rtl/apb_exe_if.sv
// APB3 bus bundle between the master and apb_exe_slave.
// Signal names keep the slave's port view (i_* driven by the master,
// o_* driven by the slave).
//   i_psel, i_penable, i_pwrite, i_paddr[AW], i_pwdata[DW] : master -> slave
//   o_prdata[DW], o_pready, o_pslverr                      : slave -> master
interface apb_exe_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          i_psel;
  logic          i_penable;
  logic          i_pwrite;
  logic [AW-1:0] i_paddr;
  logic [DW-1:0] i_pwdata;
  logic [DW-1:0] o_prdata;
  logic          o_pready;
  logic          o_pslverr;

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    input  o_prdata, o_pready, o_pslverr
  );

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    output o_prdata, o_pready, o_pslverr
  );
endinterface

// File: rtl/apb_exe_seq.sv
// Operation sequencer for apb_exe_slave.
// A START moves IDLE -> WAIT; WAIT lasts EXE_LAT cycles while the exe unit
// computes; CAPT lasts one cycle, during which the top loads the result.
// With START at edge k, capture happens at edge k+EXE_LAT+1.
// Ports:
//   i_clk, i_rsn : clock, async active-low reset
//   start        : in,  one-cycle request (only honoured in IDLE)
//   busy         : out, registered, high in WAIT and CAPT
//   capture      : out, registered, high during CAPT (load strobe)
module apb_exe_seq
  import apb_exe_pkg::*;
#(
  parameter int EXE_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rsn,
  input  logic start,
  output logic busy,
  output logic capture
);

  localparam int CW = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;

  exe_seq_state_t state_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           capture_q;

  // NOTE: state lives in flops updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      capture_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT;
            cnt_q   <= CW'(EXE_LAT - 1);
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q   <= CAPT;
            capture_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CAPT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign capture = capture_q;

endmodule

// File: rtl/apb_exe_slave.sv
// APB3 slave front-end for the exe unit: operand/opcode registers, START
// sequencing, and capture of the unit's registered result/status.
// Optional feature macro: APB_EXE_IRQ_EN (adds o_irq and register 0x14 IRQ_EN).
// Ports:
//   i_clk, i_rsn          : clock (rising edge), async active-low reset
//   apb (slave modport)   : APB3 bus; only PADDR[4:2] is decoded
//   o_argA, o_argB, o_oper: operand and opcode registers to the exe unit
//   i_result, i_status    : exe unit outputs {ERROR,ODD,ZERO,NEG}
//   o_irq (optional)      : registered DONE & IRQ_EN
module apb_exe_slave
  import apb_exe_pkg::*;
#(
  parameter int MBIT    = 4,
  parameter int NBIT    = 2,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int EXE_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rsn,
  apb_exe_if.slave        apb,
  output logic [MBIT-1:0] o_argA,
  output logic [MBIT-1:0] o_argB,
  output logic [NBIT-1:0] o_oper,
  input  logic [MBIT-1:0] i_result,
  input  logic [3:0]      i_status
`ifdef APB_EXE_IRQ_EN
  ,
  output logic            o_irq
`endif
);

`ifdef APB_EXE_IRQ_EN
  localparam reg_idx_t IDX_LAST = IDX_IRQ_EN;
`else
  localparam reg_idx_t IDX_LAST = IDX_STATUS;
`endif

  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   rdata;
  reg_idx_t        idx;
  logic            access, mapped, rd_hold, wr_blocked;
  logic            wr_commit, rd_done, start;
  logic            busy, capture;
  logic            unused_apb;

  logic [MBIT-1:0] arg_a_q, arg_a_d;
  logic [MBIT-1:0] arg_b_q, arg_b_d;
  logic [NBIT-1:0] oper_q, oper_d;
  logic [MBIT-1:0] result_q, result_d;
  logic [3:0]      status_q, status_d;
  logic            done_q, done_d;
`ifdef APB_EXE_IRQ_EN
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
`endif

  assign paddr      = apb.i_paddr;
  assign pwdata     = apb.i_pwdata;
  // Address/data bits outside the decoded fields are intentionally ignored.
  assign unused_apb = ^{paddr, pwdata};

  apb_exe_seq #(.EXE_LAT(EXE_LAT)) u_seq (
    .i_clk   (i_clk),
    .i_rsn   (i_rsn),
    .start   (start),
    .busy    (busy),
    .capture (capture)
  );

  // Decode and APB response.
  always_comb begin
    idx    = paddr[4:2];
    access = apb.i_psel & apb.i_penable;
    mapped = (idx <= IDX_LAST);
    // RESULT/STATUS reads stall (from setup onward) until the capture edge
    // has passed, so they always return the fresh value.
    rd_hold    = apb.i_psel & ~apb.i_pwrite & busy &
                 ((idx == IDX_RESULT) | (idx == IDX_STATUS));
    // Operand/opcode writes are refused while busy so the unit sees stable inputs.
    wr_blocked = apb.i_pwrite & busy & (idx <= IDX_CTRL);
    wr_commit  = access & apb.i_pwrite & mapped & ~wr_blocked;
    rd_done    = access & ~apb.i_pwrite & mapped & ~rd_hold;
    start      = wr_commit & (idx == IDX_CTRL) & pwdata[START_BIT];

    rdata = '0;
    case (idx)
      IDX_ARG_A:  rdata[MBIT-1:0] = arg_a_q;
      IDX_ARG_B:  rdata[MBIT-1:0] = arg_b_q;
      IDX_CTRL:   rdata[NBIT-1:0] = oper_q;
      IDX_RESULT: rdata[MBIT-1:0] = result_q;
      IDX_STATUS: begin
        rdata[3:0]      = status_q;
        rdata[DONE_BIT] = done_q;
        rdata[BUSY_BIT] = busy;
      end
`ifdef APB_EXE_IRQ_EN
      IDX_IRQ_EN: rdata[0] = irq_en_q;
`endif
      default:    rdata = '0;
    endcase

    apb.o_prdata  = rd_done ? rdata : '0;
    apb.o_pready  = ~rd_hold;
    apb.o_pslverr = access & (~mapped | wr_blocked);
  end

  // Next-state for the register file.
  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    arg_a_d  = arg_a_q;
    arg_b_d  = arg_b_q;
    oper_d   = oper_q;
    result_d = result_q;
    status_d = status_q;
    done_d   = done_q;
`ifdef APB_EXE_IRQ_EN
    irq_en_d = irq_en_q;
    irq_d    = done_q & irq_en_q;
`endif

    if (wr_commit) begin
      case (idx)
        IDX_ARG_A: arg_a_d = pwdata[MBIT-1:0];
        IDX_ARG_B: arg_b_d = pwdata[MBIT-1:0];
        IDX_CTRL:  oper_d  = pwdata[NBIT-1:0];
`ifdef APB_EXE_IRQ_EN
        IDX_IRQ_EN: irq_en_d = pwdata[0];
`endif
        default: ;
      endcase
    end

    if (capture) begin
      result_d = i_result;
      status_d = i_status;
    end

    // Capture is applied last so a simultaneous clear loses to the set.
    if (start || (rd_done && (idx == IDX_RESULT))) done_d = 1'b0;
    if (capture)                                   done_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      arg_a_q  <= '0;
      arg_b_q  <= '0;
      oper_q   <= '0;
      result_q <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
`ifdef APB_EXE_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      arg_a_q  <= arg_a_d;
      arg_b_q  <= arg_b_d;
      oper_q   <= oper_d;
      result_q <= result_d;
      status_q <= status_d;
      done_q   <= done_d;
`ifdef APB_EXE_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  assign o_argA = arg_a_q;
  assign o_argB = arg_b_q;
  assign o_oper = oper_q;
`ifdef APB_EXE_IRQ_EN
  assign o_irq  = irq_q;
`endif

endmodule

// File: tb/tb_apb_exe_slave.sv
// Self-checking bench for apb_exe_slave (MBIT=4, NBIT=2, EXE_LAT=1).
// A small registered stand-in for the exe unit sits downstream of the DUT.
// The reference model tracks the register map and the time of each pending
// capture in bench cycles, and predicts read data, errors and wait states.
module tb_apb_exe_slave;
  import apb_exe_pkg::*;

  localparam int MBIT    = 4;
  localparam int NBIT    = 2;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int EXE_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_exe_if #(.AW(AW), .DW(DW)) apb ();

  logic [MBIT-1:0] arg_a, arg_b, stub_res;
  logic [NBIT-1:0] oper;
  logic [3:0]      stub_stat;
`ifdef APB_EXE_IRQ_EN
  logic            irq;
`endif

  apb_exe_slave #(
    .MBIT(MBIT), .NBIT(NBIT), .AW(AW), .DW(DW), .EXE_LAT(EXE_LAT)
  ) dut (
    .i_clk    (clk),
    .i_rsn    (rst_n),
    .apb      (apb),
    .o_argA   (arg_a),
    .o_argB   (arg_b),
    .o_oper   (oper),
    .i_result (stub_res),
    .i_status (stub_stat)
`ifdef APB_EXE_IRQ_EN
    ,
    .o_irq    (irq)
`endif
  );

  // Exe unit stand-in: add / sub / and / xor, status {ERROR,ODD,ZERO,NEG}.
  function automatic logic [7:0] exe_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       e;
    case (op)
      2'd0:    begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; e = s[4]; end
      2'd1:    begin r = a - b; e = (a < b); end
      2'd2:    begin r = a & b; e = 1'b0; end
      default: begin r = a ^ b; e = (a == b); end
    endcase
    return {e, r[0], (r == 4'd0), r[3], r};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {stub_stat, stub_res} <= 8'h00;
    else        {stub_stat, stub_res} <= exe_fn(arg_a, arg_b, oper);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_arg_a, m_arg_b, m_res, m_stat, m_pend_res, m_pend_stat;
  logic [1:0] m_oper;
  bit         m_done, m_active, m_irq_en;
  int         m_cap_edge;

  task automatic m_reset();
    m_arg_a = 0; m_arg_b = 0; m_oper = 0; m_res = 0; m_stat = 0;
    m_pend_res = 0; m_pend_stat = 0;
    m_done = 0; m_active = 0; m_irq_en = 0; m_cap_edge = 0;
  endtask

  // Busy in the cycle that follows edge number c.
  function automatic bit m_busy(input int c);
    return m_active && (c < m_cap_edge);
  endfunction

  task automatic m_settle(input int c);
    if (m_active && c >= m_cap_edge) begin
      m_res = m_pend_res; m_stat = m_pend_stat; m_done = 1; m_active = 0;
    end
  endtask

  function automatic bit m_mapped(input logic [2:0] idx);
`ifdef APB_EXE_IRQ_EN
    return idx <= 3'd5;
`else
    return idx <= 3'd4;
`endif
  endfunction

  // ---------------- APB driver ----------------
  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits,
                          output int setup_cyc, output int end_cyc);
    logic done_x;
    done_x = 1'b0; waits = 0; rdata = '0; err = 1'b0;
    apb.i_psel = 1'b1; apb.i_penable = 1'b0; apb.i_pwrite = wr;
    apb.i_paddr = addr; apb.i_pwdata = wdata;
    setup_cyc = cyc;
    @(negedge clk);
    if (!apb.o_pready) waits++;
    @(posedge clk); #1;
    apb.i_penable = 1'b1;
    for (int n = 0; n < 40 && !done_x; n++) begin
      @(negedge clk);
      if (apb.o_pready) begin
        rdata = apb.o_prdata; err = apb.o_pslverr; done_x = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    end_cyc = cyc;
    check("xfer_complete", 32'(done_x), 32'd1);
    apb.i_psel = 1'b0; apb.i_penable = 1'b0; apb.i_pwrite = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        err;
    int          waits, s, e;
    logic [2:0]  idx;
    bit          exp_err;
    apb_xfer(1'b1, addr, data, rd, err, waits, s, e);
    m_settle(s + 1);
    idx     = addr[4:2];
    exp_err = !m_mapped(idx) || (idx <= 3'd2 && m_busy(s + 1));
    check({tag, "/pslverr"}, 32'(err), 32'(exp_err));
    check({tag, "/waits"}, waits, 0);
    if (!exp_err) begin
      case (idx)
        3'd0: m_arg_a = data[3:0];
        3'd1: m_arg_b = data[3:0];
        3'd2: begin
          m_oper = data[1:0];
          if (data[START_BIT]) begin
            m_active   = 1;
            m_cap_edge = e + EXE_LAT + 1;
            {m_pend_stat, m_pend_res} = exe_fn(m_arg_a, m_arg_b, m_oper);
            m_done     = 0;
          end
        end
        3'd5: m_irq_en = data[0];
        default: ;
      endcase
    end
    check({tag, "/o_argA"}, 32'(arg_a), 32'(m_arg_a));
    check({tag, "/o_argB"}, 32'(arg_b), 32'(m_arg_b));
    check({tag, "/o_oper"}, 32'(oper), 32'(m_oper));
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr);
    logic [31:0] rd, exp;
    logic        err;
    int          waits, s, e, exp_waits;
    logic [2:0]  idx;
    apb_xfer(1'b0, addr, 32'h0, rd, err, waits, s, e);
    idx       = addr[4:2];
    exp_waits = ((idx == 3'd3 || idx == 3'd4) && m_busy(s)) ? (m_cap_edge - s) : 0;
    m_settle(e - 1);
    case (idx)
      3'd0:    exp = 32'(m_arg_a);
      3'd1:    exp = 32'(m_arg_b);
      3'd2:    exp = 32'(m_oper);
      3'd3:    exp = 32'(m_res);
      3'd4:    exp = (32'(m_busy(e - 1)) << 9) | (32'(m_done) << 8) | 32'(m_stat);
      3'd5:    exp = m_mapped(idx) ? 32'(m_irq_en) : 32'h0;
      default: exp = 32'h0;
    endcase
    check({tag, "/pslverr"}, 32'(err), 32'(!m_mapped(idx)));
    check({tag, "/waits"}, waits, exp_waits);
    check({tag, "/prdata"}, rd, exp);
    if (idx == 3'd3) m_done = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/o_argA"}, 32'(arg_a), 32'h0);
    check({tag, "/o_argB"}, 32'(arg_b), 32'h0);
    check({tag, "/o_oper"}, 32'(oper), 32'h0);
    check({tag, "/prdata"}, apb.o_prdata, 32'h0);
    check({tag, "/pready"}, 32'(apb.o_pready), 32'h1);
    check({tag, "/pslverr"}, 32'(apb.o_pslverr), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  a, b;
    int          mode;
    apb.i_psel = 1'b0; apb.i_penable = 1'b0; apb.i_pwrite = 1'b0;
    apb.i_paddr = '0; apb.i_pwdata = '0;
    m_reset();

    // Reset state.
    #3;
    check_reset_outputs("reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    do_read("rst_status", ADDR_STATUS);
    do_read("rst_result", ADDR_RESULT);

    // Basic operation with STATUS poll (read stalls until capture).
    do_write("t1_arg_a", ADDR_ARG_A, 32'h5);
    do_write("t1_arg_b", ADDR_ARG_B, 32'h3);
    do_write("t1_ctrl", ADDR_CTRL, 32'h100);
    do_read("t1_status", ADDR_STATUS);
    do_read("t1_result", ADDR_RESULT);
    do_read("t1_status_after", ADDR_STATUS);

    // Second operation, different opcode; CTRL reads back only OPER.
    do_write("t2_arg_b", ADDR_ARG_B, 32'h9);
    do_write("t2_ctrl", ADDR_CTRL, 32'hFFFF_FF02);
    do_read("t2_ctrl_rd", ADDR_CTRL);
    do_read("t2_status", ADDR_STATUS);
    do_read("t2_result", ADDR_RESULT);

    // RESULT read right after START: two low-PREADY cycles, DONE cleared.
    do_write("t3_arg_a", ADDR_ARG_A, 32'hB);
    do_write("t3_ctrl", ADDR_CTRL, 32'h103);
    do_read("t3_result", ADDR_RESULT);
    do_read("t3_status", ADDR_STATUS);

    // Writes while busy are rejected; unmapped offsets error.
    do_write("t4_ctrl", ADDR_CTRL, 32'h101);
    do_write("t4_busy_arg_a", ADDR_ARG_A, 32'h7);
    do_read("t4_arg_a", ADDR_ARG_A);
    do_read("t4_unmapped_18", 8'h18);
    do_write("t4_unmapped_1c", 8'h1C, 32'hFFFF_FFFF);
    do_read("t4_irq_off", ADDR_IRQ_EN);
    do_write("t4_ro_result", ADDR_RESULT, 32'hF);
    do_read("t4_result", ADDR_RESULT);

    // Randomized operations.
    for (int it = 0; it < 30; it++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      do_write("rnd_arg_a", ADDR_ARG_A, {$urandom} & 32'hFFFF_FEFF | 32'(a));
      do_write("rnd_arg_b", ADDR_ARG_B, 32'(b));
      d = $urandom | 32'h100;
      do_write("rnd_ctrl", ADDR_CTRL, d);
      mode = $urandom_range(0, 3);
      case (mode)
        0: do_read("rnd_result_now", ADDR_RESULT);
        1: begin
          do_read("rnd_status", ADDR_STATUS);
          do_read("rnd_result", ADDR_RESULT);
        end
        2: begin
          do_write("rnd_busy_wr", 8'($urandom_range(0, 2) * 4), $urandom);
          do_read("rnd_status2", ADDR_STATUS);
          do_read("rnd_arg_b_rd", ADDR_ARG_B);
        end
        default: begin
          do_read("rnd_arg_a_busy", ADDR_ARG_A);
          idle($urandom_range(0, 3));
          do_read("rnd_status3", ADDR_STATUS);
          do_read("rnd_result3", ADDR_RESULT);
          do_read("rnd_status4", ADDR_STATUS);
        end
      endcase
      if ($urandom_range(0, 3) == 0) do_read("rnd_unmapped", 8'(8'h14 + 4 * $urandom_range(1, 2)));
      do_write("rnd_ctrl_nostart", ADDR_CTRL, $urandom & 32'hFFFF_FEFF);
      do_read("rnd_ctrl_rd", ADDR_CTRL);
    end

`ifdef APB_EXE_IRQ_EN
    // Interrupt: rises one cycle after capture, falls one edge after RESULT read.
    do_write("t6_irq_en", ADDR_IRQ_EN, 32'h1);
    do_read("t6_irq_en_rd", ADDR_IRQ_EN);
    do_write("t6_arg_a", ADDR_ARG_A, 32'h5);
    do_write("t6_arg_b", ADDR_ARG_B, 32'h3);
    do_write("t6_ctrl", ADDR_CTRL, 32'h100);
    while (cyc < m_cap_edge) idle(1);
    check("t6_irq_at_capture", 32'(irq), 32'h0);
    idle(1);
    check("t6_irq_after_capture", 32'(irq), 32'h1);
    do_read("t6_result", ADDR_RESULT);
    check("t6_irq_read_edge", 32'(irq), 32'h1);
    idle(1);
    check("t6_irq_cleared", 32'(irq), 32'h0);
`endif

    // Reset in the middle of an operation.
    do_write("t5_arg_a", ADDR_ARG_A, 32'h6);
    do_write("t5_ctrl", ADDR_CTRL, 32'h101);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("t5_reset");
    m_reset();
    idle(2);
    rst_n = 1'b1;
    idle(5);
    do_read("t5_status", ADDR_STATUS);
    do_read("t5_result", ADDR_RESULT);
    do_read("t5_arg_a", ADDR_ARG_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
